// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then shifts one
// command byte out on device-generated clock edges and checks the device acknowledge.
module ps2_host_transmitter #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iStart,
    input  logic [7:0] iData,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DATA,
    output logic       oPS2_CLK_OE,
    output logic       oPS2_DATA_OE,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IN_W = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IN_W-1:0] IN_LAST = IN_W'(INHIBIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE
    } state_t;

    state_t          state;
    logic [7:0]      data_q;
    logic            parity_q;
    logic [3:0]      bit_idx;
    logic [IN_W-1:0] inhibit_cnt;
    logic [TO_W-1:0] timeout_cnt;
    logic            ack_missing;

    logic clk_meta, clk_sync, clk_prev;
    logic data_meta, data_sync;

    // Idle bus level is high, so presetting the chains avoids a false edge after reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples
            // the pre-edge value of its neighbour; blocking here would collapse the chain.
            clk_meta  <= iPS2_CLK;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= iPS2_DATA;
            data_sync <= data_meta;
        end
    end

    logic ps2_fe;
    logic lines_idle;
    logic watching;
    logic abort;

    assign ps2_fe     = clk_prev & ~clk_sync;
    assign lines_idle = clk_sync & data_sync;
    assign watching   = (state == S_SHIFT) || (state == S_ACK) || (state == S_WAIT_IDLE);
    // Completion in WAIT_IDLE wins over a timeout landing in the same cycle.
    assign abort      = watching && !ps2_fe && (timeout_cnt == TO_LAST)
                        && !((state == S_WAIT_IDLE) && lines_idle);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= S_IDLE;
            data_q       <= '0;
            parity_q     <= 1'b0;
            bit_idx      <= '0;
            inhibit_cnt  <= '0;
            timeout_cnt  <= '0;
            ack_missing  <= 1'b0;
            oPS2_CLK_OE  <= 1'b0;
            oPS2_DATA_OE <= 1'b0;
            oBusy        <= 1'b0;
            oDone        <= 1'b0;
            oError       <= 1'b0;
        end else begin
            if (watching) begin
                if (ps2_fe) begin
                    timeout_cnt <= '0;
                end else if (timeout_cnt != TO_LAST) begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                end
            end

            case (state)
                // DONE already shows oBusy=0, so it accepts a new request just like IDLE.
                S_IDLE, S_DONE: begin
                    oDone <= 1'b0;
                    state <= S_IDLE;
                    if (iStart) begin
                        data_q      <= iData;
                        parity_q    <= ~^iData;
                        oError      <= 1'b0;
                        oBusy       <= 1'b1;
                        oPS2_CLK_OE <= 1'b1;
                        inhibit_cnt <= '0;
                        state       <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (inhibit_cnt == IN_LAST) begin
                        oPS2_DATA_OE <= 1'b1;
                        state        <= S_REQ;
                    end else begin
                        inhibit_cnt <= inhibit_cnt + 1'b1;
                    end
                end

                S_REQ: begin
                    oPS2_CLK_OE <= 1'b0;
                    bit_idx     <= '0;
                    timeout_cnt <= '0;
                    state       <= S_SHIFT;
                end

                // Data is changed on device falling edges; the device samples on rising edges.
                S_SHIFT: begin
                    if (ps2_fe) begin
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx < 4'd8) begin
                            oPS2_DATA_OE <= ~data_q[bit_idx[2:0]];
                        end else if (bit_idx == 4'd8) begin
                            oPS2_DATA_OE <= ~parity_q;
                        end else begin
                            oPS2_DATA_OE <= 1'b0;
                            state        <= S_ACK;
                        end
                    end
                end

                S_ACK: begin
                    if (ps2_fe) begin
                        ack_missing <= data_sync;
                        state       <= S_WAIT_IDLE;
                    end
                end

                S_WAIT_IDLE: begin
                    if (lines_idle) begin
                        oBusy  <= 1'b0;
                        oDone  <= 1'b1;
                        oError <= ack_missing;
                        state  <= S_DONE;
                    end
                end

                default: state <= S_IDLE;
            endcase

            if (abort) begin
                oPS2_CLK_OE  <= 1'b0;
                oPS2_DATA_OE <= 1'b0;
                oBusy        <= 1'b0;
                oDone        <= 1'b1;
                oError       <= 1'b1;
                state        <= S_DONE;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Directed bench for ps2_host_transmitter: a behavioural PS/2 device clocks frames out of
// the host and acknowledges (or not); each scenario task checks its own results.
module tb_ps2_host_transmitter;

    localparam int INH = 20;
    localparam int TO  = 200;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       iStart;
    logic [7:0] iData;
    logic       iPS2_CLK;
    logic       iPS2_DATA;
    logic       oPS2_CLK_OE;
    logic       oPS2_DATA_OE;
    logic       oBusy;
    logic       oDone;
    logic       oError;

    logic dev_clk_pull  = 1'b0;
    logic dev_data_pull = 1'b0;

    // Open-drain bus: either side can pull low, otherwise the pull-up wins.
    assign iPS2_CLK  = ~(oPS2_CLK_OE | dev_clk_pull);
    assign iPS2_DATA = ~(oPS2_DATA_OE | dev_data_pull);

    int checks     = 0;
    int passes     = 0;
    int done_count = 0;
    logic err_at_done = 1'b0;

    // Frames as {stop, parity, D7..D0, start}; bit 0 is the first bit the device samples.
    localparam logic [10:0] FRAME_ED = {1'b1, 1'b1, 8'hED, 1'b0};
    localparam logic [10:0] FRAME_FF = {1'b1, 1'b1, 8'hFF, 1'b0};
    localparam logic [10:0] FRAME_F4 = {1'b1, 1'b0, 8'hF4, 1'b0};

    ps2_host_transmitter #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .iStart      (iStart),
        .iData       (iData),
        .iPS2_CLK    (iPS2_CLK),
        .iPS2_DATA   (iPS2_DATA),
        .oPS2_CLK_OE (oPS2_CLK_OE),
        .oPS2_DATA_OE(oPS2_DATA_OE),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .oError      (oError)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (oDone) begin
            done_count++;
            err_at_done = oError;
        end
    end

    // Device side: 40-cycle clock period, data sampled mid-way through each high phase.
    // n_fe limits how many falling edges are produced; 10 means a full frame plus ack.
    task automatic device_frame(input bit do_ack, input int n_fe,
                                output logic [10:0] bits, output bit ok);
        int t;
        bits = '1;
        ok   = 1'b1;
        t = 0;
        while (!oPS2_CLK_OE && t < 200) begin @(negedge Clock); t++; end
        t = 0;
        while (oPS2_CLK_OE && t < 200) begin @(negedge Clock); t++; end
        if (t >= 200) begin
            ok = 1'b0;
            return;
        end
        for (int i = 0; i < 11; i++) begin
            repeat (10) @(negedge Clock);
            bits[i] = iPS2_DATA;
            repeat (10) @(negedge Clock);
            if (i == 10) break;
            if (i >= n_fe) return;
            dev_clk_pull = 1'b1;
            repeat (20) @(negedge Clock);
            dev_clk_pull = 1'b0;
        end
        if (do_ack) dev_data_pull = 1'b1;
        repeat (5) @(negedge Clock);
        dev_clk_pull = 1'b1;
        repeat (20) @(negedge Clock);
        dev_clk_pull = 1'b0;
        repeat (5) @(negedge Clock);
        dev_data_pull = 1'b0;
    endtask

    task automatic start_tx(input logic [7:0] d);
        @(negedge Clock);
        iData  = d;
        iStart = 1'b1;
        @(negedge Clock);
        iStart = 1'b0;
    endtask

    task automatic wait_not_busy(output bit ok);
        int t = 0;
        while (oBusy && t < 400) begin @(negedge Clock); t++; end
        @(negedge Clock);
        ok = (t < 400);
    endtask

    task automatic test_reset;
        Reset  = 1'b1;
        iStart = 1'b0;
        iData  = 8'h00;
        repeat (3) @(negedge Clock);
        checks++;
        if ({oPS2_CLK_OE, oPS2_DATA_OE, oBusy, oDone, oError} !== 5'b0)
            $display("FAIL reset_outputs: got %b expected 00000",
                     {oPS2_CLK_OE, oPS2_DATA_OE, oBusy, oDone, oError});
        else passes++;
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        checks++;
        if ({oPS2_CLK_OE, oPS2_DATA_OE, oBusy} !== 3'b0)
            $display("FAIL post_reset_idle: got %b expected 000",
                     {oPS2_CLK_OE, oPS2_DATA_OE, oBusy});
        else passes++;
    endtask

    task automatic test_send_ed;
        logic [10:0] bits;
        bit ok, ok_idle;
        int n = 0;
        int done0 = done_count;
        start_tx(8'hED);
        checks++;
        if (oBusy !== 1'b1) $display("FAIL ed_busy_after_start: got %b expected 1", oBusy);
        else passes++;
        fork
            begin
                while (oPS2_CLK_OE && !oPS2_DATA_OE && n < 1000) begin n++; @(negedge Clock); end
                checks++;
                if (n !== INH) $display("FAIL ed_inhibit_len: got %0d expected %0d", n, INH);
                else passes++;
                checks++;
                if ({oPS2_CLK_OE, oPS2_DATA_OE} !== 2'b11)
                    $display("FAIL ed_req_lines: got %b expected 11", {oPS2_CLK_OE, oPS2_DATA_OE});
                else passes++;
                @(negedge Clock);
                checks++;
                if ({oPS2_CLK_OE, oPS2_DATA_OE} !== 2'b01)
                    $display("FAIL ed_shift_entry: got %b expected 01", {oPS2_CLK_OE, oPS2_DATA_OE});
                else passes++;
            end
            device_frame(1'b1, 10, bits, ok);
        join
        wait_not_busy(ok_idle);
        checks++;
        if (!(ok && ok_idle)) $display("FAIL ed_handshake: got %b%b expected 11", ok, ok_idle);
        else passes++;
        checks++;
        if (bits !== FRAME_ED) $display("FAIL ed_frame: got %b expected %b", bits, FRAME_ED);
        else passes++;
        checks++;
        if (done_count !== done0 + 1) $display("FAIL ed_done_pulses: got %0d expected 1", done_count - done0);
        else passes++;
        checks++;
        if (err_at_done !== 1'b0 || oError !== 1'b0)
            $display("FAIL ed_error: got %b/%b expected 0/0", err_at_done, oError);
        else passes++;
    endtask

    task automatic test_nack_ff;
        logic [10:0] bits;
        bit ok, ok_idle;
        int done0 = done_count;
        start_tx(8'hFF);
        device_frame(1'b0, 10, bits, ok);
        wait_not_busy(ok_idle);
        checks++;
        if (bits !== FRAME_FF || !ok) $display("FAIL ff_frame: got %b expected %b", bits, FRAME_FF);
        else passes++;
        checks++;
        if (done_count !== done0 + 1 || !ok_idle)
            $display("FAIL ff_done_pulses: got %0d expected 1", done_count - done0);
        else passes++;
        checks++;
        if (err_at_done !== 1'b1 || oError !== 1'b1)
            $display("FAIL ff_nack_error: got %b/%b expected 1/1", err_at_done, oError);
        else passes++;
    endtask

    task automatic test_timeout;
        logic [10:0] bits;
        bit ok;
        int n = 0;
        int done0 = done_count;
        start_tx(8'hF4);
        // The device returns 40 cycles after its 4th falling edge; wait to ~160 past it.
        device_frame(1'b1, 4, bits, ok);
        repeat (120) @(negedge Clock);
        checks++;
        if ({ok, oBusy, oPS2_DATA_OE} !== 3'b111 || done_count !== done0)
            $display("FAIL to_still_waiting: got ok/busy/doe=%b done=%0d expected 111 done=0",
                     {ok, oBusy, oPS2_DATA_OE}, done_count - done0);
        else passes++;
        while (!oDone && n < 100) begin @(negedge Clock); n++; end
        checks++;
        if (n < 35 || n > 50) $display("FAIL to_latency: got %0d extra cycles expected 35..50", n);
        else passes++;
        checks++;
        if ({oPS2_CLK_OE, oPS2_DATA_OE, oBusy, oError} !== 4'b0001)
            $display("FAIL to_abort_state: got %b expected 0001",
                     {oPS2_CLK_OE, oPS2_DATA_OE, oBusy, oError});
        else passes++;
        repeat (5) @(negedge Clock);
        checks++;
        if (done_count !== done0 + 1) $display("FAIL to_done_pulses: got %0d expected 1", done_count - done0);
        else passes++;
    endtask

    task automatic test_busy_ignored;
        logic [10:0] bits;
        bit ok, ok_idle;
        int done0 = done_count;
        start_tx(8'hF4);
        fork
            device_frame(1'b1, 10, bits, ok);
            begin
                repeat (3) @(negedge Clock);
                iData = 8'h00;
                repeat (100) @(negedge Clock);
                iStart = 1'b1;
                @(negedge Clock);
                iStart = 1'b0;
            end
        join
        wait_not_busy(ok_idle);
        repeat (5) @(negedge Clock);
        checks++;
        if (bits !== FRAME_F4 || !ok) $display("FAIL busy_frame: got %b expected %b", bits, FRAME_F4);
        else passes++;
        checks++;
        if (done_count !== done0 + 1 || !ok_idle || oBusy !== 1'b0)
            $display("FAIL busy_single_done: got %0d busy=%b expected 1 busy=0", done_count - done0, oBusy);
        else passes++;
    endtask

    task automatic test_reset_mid;
        logic [10:0] bits;
        bit ok, ok_idle;
        int done0;
        start_tx(8'hF4);
        // After two falling edges the host drives ~D1 = 1 on DATA_OE.
        device_frame(1'b1, 2, bits, ok);
        checks++;
        if ({ok, oBusy, oPS2_DATA_OE} !== 3'b111)
            $display("FAIL rst_pre_state: got %b expected 111", {ok, oBusy, oPS2_DATA_OE});
        else passes++;
        #2 Reset = 1'b1;
        #1;
        checks++;
        if ({oPS2_CLK_OE, oPS2_DATA_OE, oBusy} !== 3'b000)
            $display("FAIL rst_async_release: got %b expected 000", {oPS2_CLK_OE, oPS2_DATA_OE, oBusy});
        else passes++;
        @(negedge Clock);
        Reset = 1'b0;
        repeat (60) @(negedge Clock);
        checks++;
        if ({oPS2_CLK_OE, oPS2_DATA_OE, oBusy} !== 3'b000)
            $display("FAIL rst_no_resume: got %b expected 000", {oPS2_CLK_OE, oPS2_DATA_OE, oBusy});
        else passes++;
        done0 = done_count;
        start_tx(8'hF4);
        device_frame(1'b1, 10, bits, ok);
        wait_not_busy(ok_idle);
        checks++;
        if (bits !== FRAME_F4 || !ok) $display("FAIL rst_after_frame: got %b expected %b", bits, FRAME_F4);
        else passes++;
        checks++;
        if (done_count !== done0 + 1 || err_at_done !== 1'b0 || !ok_idle)
            $display("FAIL rst_after_done: got %0d err=%b expected 1 err=0", done_count - done0, err_at_done);
        else passes++;
    endtask

    task automatic test_back_to_back;
        logic [10:0] b1, b2;
        bit ok1, ok2, ok_idle;
        int t = 0;
        int gap = 0;
        int done0 = done_count;
        @(negedge Clock);
        iData  = 8'hED;
        iStart = 1'b1;
        @(negedge Clock);
        fork
            begin
                device_frame(1'b1, 10, b1, ok1);
                device_frame(1'b1, 10, b2, ok2);
            end
            begin
                iData = 8'hF4;
                while (oBusy && t < 3000) begin @(negedge Clock); t++; end
                while (!oBusy && gap < 10) begin gap++; @(negedge Clock); end
                iStart = 1'b0;
                checks++;
                if (gap !== 1) $display("FAIL b2b_idle_gap: got %0d expected 1", gap);
                else passes++;
            end
        join
        wait_not_busy(ok_idle);
        repeat (5) @(negedge Clock);
        checks++;
        if (b1 !== FRAME_ED || b2 !== FRAME_F4 || !ok1 || !ok2)
            $display("FAIL b2b_frames: got %b,%b expected %b,%b", b1, b2, FRAME_ED, FRAME_F4);
        else passes++;
        checks++;
        if (done_count !== done0 + 2 || oBusy !== 1'b0 || err_at_done !== 1'b0)
            $display("FAIL b2b_done_pulses: got %0d busy=%b err=%b expected 2 busy=0 err=0",
                     done_count - done0, oBusy, err_at_done);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_nack_ff();
        test_timeout();
        test_busy_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
